lsu_mem_port: RTL and testbench

- Load/store initiator that drives the unified word-indexed memory (`clk`, `addr`, `din`, `rd`, `we`) on behalf of the multi-cycle RISC-V core.
- Accepts one byte-addressed load/store request per transaction using RISC-V funct3 encodings, and converts the byte address to a word index.
- Sub-word stores are done as read-modify-write, because the memory writes whole words only.
- Returns aligned, sign- or zero-extended load data and an error flag for misaligned, out-of-range or illegal accesses.

---
 rtl/lsu_mem_port_if.sv | 31 +++
 rtl/lsu_mem_port.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_mem_port_if : request/response and memory-side bundle for lsu_mem_port
// Rev 1.0
// ---------------------------------------------------------------------------
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_mem_port : byte-addressed load/store front end for a word-wide memory;
//                sub-word stores are performed as read-modify-write.
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu_mem_port #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  lsu_mem_port_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [15:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        is_sw;
  logic [31:0] rd_shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign is_sw  = bus.req_we && (bus.req_funct3 == 3'b010);

  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if ({1'b0, bus.req_addr} >= ADDR_LIMIT) begin
      req_err = 1'b1;
    end
  end

  // Little-endian lane extraction from the word currently on mem_rd.
  assign rd_shifted = bus.mem_rd >> {lo_q, 3'b000};
  assign byte_sel   = rd_shifted[7:0];
  assign half_sel   = lo_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

  always_comb begin
    load_data = bus.mem_rd;
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = bus.mem_rd;
    endcase
  end

  always_comb begin
    merge_data = bus.mem_rd;
    if (f3_q[0]) begin
      if (lo_q[1]) merge_data[31:16] = wdata_q;
      else         merge_data[15:0]  = wdata_q;
    end else begin
      merge_data[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)    state_d = S_DONE;
          else if (is_sw) state_d = S_WR;
          else            state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      lo_q       <= 2'd0;
      wdata_q    <= 16'd0;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q       <= bus.req_we;
            f3_q       <= bus.req_funct3;
            lo_q       <= bus.req_addr[1:0];
            wdata_q    <= bus.req_wdata[15:0];
            mem_addr_q <= {2'b00, bus.req_addr[31:2]};
            err_q      <= req_err;
            rdata_q    <= 32'd0;
            if (is_sw && !req_err) begin
              mem_din_q <= bus.req_wdata;
            end
          end
        end
        S_RD: begin
          if (we_q) mem_din_q <= merge_data;
          else      rdata_q   <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.mem_we     = (state_q == S_WR);

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu_mem_port : directed scoreboard bench for lsu_mem_port with a
//                   behavioural word memory.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu_mem_port;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_at;
    logic [31:0] waddr;
    logic [31:0] din;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lsu_mem_port_if bus ();

  lsu_mem_port #(.MEM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pre_we   = 1'b0;
  logic [9:0]  pre_addr = 10'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[9:0]] <= bus.mem_din;
    if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign bus.mem_rd = mem[bus.mem_addr[9:0]];

  int acc_cnt = 0;
  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) acc_cnt++;
  end

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Drive a request until accepted; returns 1 on accept.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output bit ok);
    bit rdy;
    int n;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr;  bus.req_wdata = wdata;
    n = 0;
    do begin
      rdy = bus.req_ready;
      tick();
      n++;
    end while (!rdy && n < 20);
    ok = rdy;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                        input int e_we_at, input logic [31:0] e_din, input bit hold);
    exp_t e, got_e;
    bit ok, got;
    int k, wcnt, we_at, acc0;
    logic [31:0] wa, wd;
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.we_at = e_we_at;
    e.waddr = {2'b00, addr[31:2]}; e.din = e_din;
    sb.push_back(e);
    acc0 = acc_cnt;
    send(we, f3, addr, wdata, ok);
    chk({tag, ".accept"}, 32'(ok), 32'd1);
    if (!hold) bus.req_valid = 1'b0;
    k = 1; got = 1'b0; wcnt = 0; we_at = -1; wa = '0; wd = '0;
    while (k <= 10) begin
      if (bus.mem_we !== 1'b0) begin wcnt++; we_at = k; wa = bus.mem_addr; wd = bus.mem_din; end
      if (bus.resp_valid === 1'b1) begin got = 1'b1; break; end
      tick();
      k++;
    end
    bus.req_valid = 1'b0;
    got_e = sb.pop_front();
    chk({tag, ".resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, ".lat"},   32'(k), 32'(got_e.lat));
      chk({tag, ".rdata"}, bus.resp_rdata, got_e.rdata);
      chk({tag, ".err"},   32'(bus.resp_err), 32'(got_e.err));
    end
    chk({tag, ".we_cnt"}, 32'(wcnt), (got_e.we_at < 0) ? 32'd0 : 32'd1);
    if (got_e.we_at >= 0) begin
      chk({tag, ".we_at"}, 32'(we_at), 32'(got_e.we_at));
      chk({tag, ".waddr"}, wa, got_e.waddr);
      chk({tag, ".wdin"},  wd, got_e.din);
    end
    tick();
    chk({tag, ".pulse_end"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, ".ready_after"}, 32'(bus.req_ready), 32'd1);
    if (hold) chk({tag, ".one_accept"}, 32'(acc_cnt - acc0), 32'd1);
  endtask

  initial begin
    int rv, wv;
    bit ok;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

    repeat (2) tick();
    preload(10'd4, 32'h8899AABB);
    preload(10'd5, 32'h00000000);
    preload(10'd1023, 32'h0BADF00D);
    rst = 1'b0;

    chk("rst.ready",  32'(bus.req_ready), 32'd1);
    chk("rst.rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst.err",    32'(bus.resp_err), 32'd0);
    chk("rst.rdata",  bus.resp_rdata, 32'd0);
    chk("rst.maddr",  bus.mem_addr, 32'd0);
    chk("rst.mdin",   bus.mem_din, 32'd0);
    chk("rst.mwe",    32'(bus.mem_we), 32'd0);

    do_req("lw10",  0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 0, 2, -1, 32'h0, 0);
    do_req("lb11",  0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2, -1, 32'h0, 0);
    do_req("lbu11", 0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 0, 2, -1, 32'h0, 0);
    do_req("lh12",  0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 0, 2, -1, 32'h0, 0);
    do_req("lhu12", 0, 3'b101, 32'h12, 32'h0, 32'h00008899, 0, 2, -1, 32'h0, 0);
    do_req("lb10",  0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 0, 2, -1, 32'h0, 0);
    do_req("lwtop", 0, 3'b010, 32'hFFC, 32'h0, 32'h0BADF00D, 0, 2, -1, 32'h0, 0);

    do_req("sb12",  1, 3'b000, 32'h12, 32'h12345677, 32'h0, 0, 3, 2, 32'h8877AABB, 0);
    do_req("lw10b", 0, 3'b010, 32'h10, 32'h0, 32'h8877AABB, 0, 2, -1, 32'h0, 0);

    do_req("sw14",  1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF, 0);
    chk("mem5.sw", mem[5], 32'hDEADBEEF);
    do_req("sh16",  1, 3'b001, 32'h16, 32'h1234CAFE, 32'h0, 0, 3, 2, 32'hCAFEBEEF, 0);
    chk("mem5.sh", mem[5], 32'hCAFEBEEF);
    do_req("lw14",  0, 3'b010, 32'h14, 32'h0, 32'hCAFEBEEF, 0, 2, -1, 32'h0, 0);

    do_req("e_lw13",   0, 3'b010, 32'h13,   32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
    do_req("e_sh15",   1, 3'b001, 32'h15,   32'hFFFF, 32'h0, 1, 1, -1, 32'h0, 0);
    do_req("e_lw1000", 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
    do_req("e_f3_011", 0, 3'b011, 32'h10,   32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
    do_req("e_st100",  1, 3'b100, 32'h10,   32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
    do_req("e_lh13",   0, 3'b001, 32'h13,   32'h0, 32'h0, 1, 1, -1, 32'h0, 0);

    // Reset while the SB read phase is in progress.
    send(1'b1, 3'b000, 32'h10, 32'h00000055, ok);
    bus.req_valid = 1'b0;
    chk("rrd.accept", 32'(ok), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rrd.ready", 32'(bus.req_ready), 32'd1);
    rv = 0; wv = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid !== 1'b0) rv++;
      if (bus.mem_we !== 1'b0) wv++;
      tick();
    end
    chk("rrd.no_resp", 32'(rv), 32'd0);
    chk("rrd.no_we",   32'(wv), 32'd0);
    chk("rrd.mem4",    mem[4], 32'h8877AABB);

    do_req("hold_lw", 0, 3'b010, 32'h10, 32'h0, 32'h8877AABB, 0, 2, -1, 32'h0, 1);
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
